// File: rtl/dmem_wait_responder.sv
// Data-memory responder for the CPU load/store port with programmable wait states.
// Latency: a request captured in IDLE gets its ready pulse WAIT_CYCLES+1 edges later; illegal requests respond after one edge.
// Backpressure: stall = req & ~ready; a new request is sampled only in IDLE, so the peak rate is one per WAIT_CYCLES+2 cycles.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req                 request valid, held stable with its fields until ready
//   we/dmtype/addr/wdata  store enable, access type, byte address, right-aligned store data
//   ready               one-cycle completion pulse
//   rdata/err           load result / illegal-access flag, valid only while ready=1
//   stall               combinational stall to the pipeline
module dmem_wait_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  dmtype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        stall
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam int         AW     = DEPTH_LOG2 + 2;
    localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

    localparam logic [2:0] DT_W  = 3'b000;
    localparam logic [2:0] DT_H  = 3'b001;
    localparam logic [2:0] DT_HU = 3'b010;
    localparam logic [2:0] DT_B  = 3'b011;
    localparam logic [2:0] DT_BU = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        cap;
    logic        commit;

    // Captured request, used while WAIT hides the live inputs.
    logic        we_q;
    logic [2:0]  dmtype_q;
    logic [AW-1:0] addr_q;
    logic [31:0] wdata_q;

    // Effective access fields: live inputs in IDLE, captured copy otherwise.
    logic        acc_we;
    logic [2:0]  acc_dt;
    logic [AW-1:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_illegal;

    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;
    logic [31:0] rd_shift;
    logic [31:0] load_val;
    logic [31:0] resp_data;
    logic [31:0] wr_word;
    logic [3:0]  wr_mask;

    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_dt    = dmtype;
            acc_addr  = addr[AW-1:0];
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_dt    = dmtype_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        acc_illegal = 1'b0;
        if (acc_dt > DT_BU) begin
            acc_illegal = 1'b1;
        end else if ((acc_dt == DT_H || acc_dt == DT_HU) && acc_addr[0]) begin
            acc_illegal = 1'b1;
        end else if (acc_dt == DT_W && acc_addr[1:0] != 2'b00) begin
            acc_illegal = 1'b1;
        end
    end

    // Next-state logic. The counter is loaded with WAIT_CYCLES and leaves WAIT
    // while it reads 1, so WAIT lasts exactly WAIT_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cap = 1'b1;
                    if (acc_illegal || WAIT_L == 4'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_L;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The access takes effect on the edge that enters RESP.
    assign commit = (state_d == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            dmtype_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
        end else if (cap) begin
            we_q     <= we;
            dmtype_q <= dmtype;
            addr_q   <= addr[AW-1:0];
            wdata_q  <= wdata;
        end
    end

    // Upper address bits are dropped here, so addresses alias modulo the array size.
    assign idx      = acc_addr[AW-1:2];
    assign rd_word  = mem[idx];
    assign rd_shift = rd_word >> {acc_addr[1:0], 3'b000};

    always_comb begin
        load_val = 32'd0;
        case (acc_dt)
            DT_W:    load_val = rd_word;
            DT_H:    load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            DT_HU:   load_val = {16'd0, rd_shift[15:0]};
            DT_B:    load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            DT_BU:   load_val = {24'd0, rd_shift[7:0]};
            default: load_val = 32'd0;
        endcase
    end

    assign resp_data = (acc_illegal || acc_we) ? 32'd0 : load_val;

    // Store data is replicated across lanes; the mask picks which lanes land.
    always_comb begin
        wr_word = acc_wdata;
        wr_mask = 4'b0000;
        case (acc_dt)
            DT_W: begin
                wr_word = acc_wdata;
                wr_mask = 4'b1111;
            end
            DT_H, DT_HU: begin
                wr_word = {2{acc_wdata[15:0]}};
                wr_mask = acc_addr[1] ? 4'b1100 : 4'b0011;
            end
            DT_B, DT_BU: begin
                wr_word = {4{acc_wdata[7:0]}};
                wr_mask = 4'b0001 << acc_addr[1:0];
            end
            default: begin
                wr_word = acc_wdata;
                wr_mask = 4'b0000;
            end
        endcase
    end

    // No reset on the array; reset still blocks a store whose commit edge it shares.
    always_ff @(posedge clk) begin
        if (!rst && commit && acc_we && !acc_illegal) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Response registers are zero in every cycle other than RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            ready <= commit;
            rdata <= commit ? resp_data : 32'd0;
            err   <= commit & acc_illegal;
        end
    end

    assign stall = req & ~ready;

endmodule
